// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory (DM).
// One access at a time: a write takes IDLE+ACCESS, a read adds a RESP cycle.
module dm_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [9:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [9:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        dm_dmwr,
  output logic        dm_wren,
  output logic [9:0]  dm_address,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]                  state;
  logic                        last_grant;
  logic                        winner;
  logic                        pick;
  logic [NUM_PORTS-1:0]        req, we, gnt_q, rvalid_q;
  logic [NUM_PORTS-1:0][9:0]   addr;
  logic [NUM_PORTS-1:0][31:0]  wdata, rdata_q, rdata;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  // On a tie the port that did not win last time goes first.
  always_comb begin
    pick = req[1];
    if (req[0] && req[1]) pick = ~last_grant;
  end

  // The dm_* flops double as the latched request; dm_dmwr doubles as the latched we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      dm_wren    <= 1'b0;
      dm_dmwr    <= 1'b0;
      dm_address <= '0;
      dm_din     <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      dm_wren  <= 1'b0;
      dm_dmwr  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= ACCESS;
            winner      <= pick;
            last_grant  <= pick;
            gnt_q[pick] <= 1'b1;
            dm_wren     <= 1'b1;
            dm_dmwr     <= we[pick];
            dm_address  <= addr[pick];
            dm_din      <= wdata[pick];
          end
        end
        ACCESS: begin
          if (dm_dmwr) begin
            state <= IDLE;
          end else begin
            state            <= RESP;
            rvalid_q[winner] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst_n)           rdata_q[i] <= '0;
      else if (rvalid_q[i]) rdata_q[i] <= dm_dout;
    end
  end

  // DM dout is only valid during RESP, so pass it through live and hold it afterwards.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign rdata[i] = rvalid_q[i] ? dm_dout : rdata_q[i];
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level occupancy model predicts
// every grant/return; a monitor compares whatever the DUT presents.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic        we [2];
  logic [9:0]  addr [2];
  logic [31:0] wdata [2];
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dm_dmwr, dm_wren, busy;
  logic [9:0]  dm_address;
  logic [31:0] dm_din, dm_dout;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_dmwr(dm_dmwr), .dm_wren(dm_wren), .dm_address(dm_address),
    .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
  );

  // Data memory with registered read port.
  always @(posedge clk) begin
    if (dm_wren) begin
      if (dm_dmwr) mem[dm_address] <= dm_din;
      else         dm_dout <= mem[dm_address];
    end
  end

  typedef struct packed {
    logic        port;
    int          cyc;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  int          checks = 0, failures = 0;
  int          cyc = 0, free_at = 0, prev = 0;
  int          gc [2];
  logic        last = 1'b1, rst_smp = 1'b0, exp_busy = 1'b0;
  logic [31:0] ref_mem [1024];
  exp_t        egq [$];
  exp_t        erq [$];
  logic [31:0] hold [2];
  logic [9:0]  exp_addr;
  logic [31:0] exp_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the arbiter is free again 2 cycles after a write is taken, 3 after a read.
  initial forever begin
    logic w;
    @(posedge clk);
    cyc++;
    rst_smp = rst_n;
    if (!rst_n) begin
      free_at = cyc + 1;
      last = 1'b1;
      egq.delete();
      erq.delete();
    end else if (cyc >= free_at && (req[0] || req[1])) begin
      w = (req[0] && req[1]) ? !last : req[1];
      last = w;
      egq.push_back('{port: w, cyc: cyc, we: we[w], addr: addr[w], data: wdata[w]});
      if (we[w]) begin
        ref_mem[addr[w]] = wdata[w];
        free_at = cyc + 2;
      end else begin
        erq.push_back('{port: w, cyc: cyc + 1, we: 1'b0, addr: addr[w], data: ref_mem[addr[w]]});
        free_at = cyc + 3;
      end
    end
    exp_busy = (free_at > cyc + 1);
  end

  // Monitor
  initial begin
    hold[0] = '0; hold[1] = '0; exp_addr = '0; exp_din = '0;
    forever begin
      exp_t e;
      logic gp, rp;
      @(negedge clk);
      if (!rst_smp) begin
        hold[0] = '0; hold[1] = '0; exp_addr = '0; exp_din = '0;
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("gnt_excl", 32'(p0_gnt & p1_gnt), 32'd0);
      chk("rvalid_excl", 32'(p0_rvalid & p1_rvalid), 32'd0);
      chk("wren_eq_gnt", 32'(dm_wren), 32'(p0_gnt | p1_gnt));
      if (p0_gnt || p1_gnt) begin
        gp = p1_gnt;
        if (egq.size() == 0) chk("gnt_unexpected", 32'(egq.size()), 32'd1);
        else begin
          e = egq.pop_front();
          chk("gnt_port", 32'(gp), 32'(e.port));
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("dm_dmwr", 32'(dm_dmwr), 32'(e.we));
          chk("dm_address", 32'(dm_address), 32'(e.addr));
          chk("dm_din", dm_din, e.data);
          exp_addr = e.addr;
          exp_din  = e.data;
        end
      end else begin
        chk("dm_dmwr_idle", 32'(dm_dmwr), 32'd0);
        chk("dm_address_hold", 32'(dm_address), 32'(exp_addr));
        chk("dm_din_hold", dm_din, exp_din);
      end
      if (p0_rvalid || p1_rvalid) begin
        rp = p1_rvalid;
        if (erq.size() == 0) chk("rvalid_unexpected", 32'(erq.size()), 32'd1);
        else begin
          e = erq.pop_front();
          chk("rvalid_port", 32'(rp), 32'(e.port));
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", rp ? p1_rdata : p0_rdata, e.data);
          hold[rp] = e.data;
        end
      end
      if (!p0_rvalid) chk("p0_rdata_hold", p0_rdata, hold[0]);
      if (!p1_rvalid) chk("p1_rdata_hold", p1_rdata, hold[1]);
    end
  end

  task automatic set_req(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic wait_gnt(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? p1_gnt : p0_gnt) && n < 100);
    chk("gnt_wait", 32'(p ? p1_gnt : p0_gnt), 32'd1);
    gc[p] = cyc;
  endtask

  // Called at posedge+1; returns at posedge+1 after the ACCESS cycle.
  task automatic req_txn(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    set_req(p, w, a, d);
    wait_gnt(p);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic check_rst_outs(input string tag);
    chk({tag, "_ctl"}, 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_wren, dm_dmwr, busy}), 32'd0);
    chk({tag, "_addr"}, 32'(dm_address), 32'd0);
    chk({tag, "_din"}, dm_din, 32'd0);
    chk({tag, "_rdata"}, p0_rdata | p1_rdata, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_rst_outs(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Random traffic; an occasional one-cycle pulse is followed by a gap so a
  // late grant of the pulse is never mistaken for the next request's grant.
  task automatic drive(input int p, input int n);
    bit need_gap = 1'b0;
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      if (need_gap && gap == 0) gap = 1;
      if (gap > 0) begin
        req[p] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      set_req(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      need_gap = ($urandom_range(0, 7) == 0);
      if (need_gap) begin
        @(posedge clk); #1;
        req[p] = 1'b0;
      end else begin
        wait_gnt(p);
        @(posedge clk); #1;
      end
    end
    req[p] = 1'b0;
  endtask

  initial begin
    int seen;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; gc[p] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst_outs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    req_txn(0, 1'b1, 10'h005, 32'hDEADBEEF);
    chk("mem5", mem[5], 32'hDEADBEEF);
    req_txn(0, 1'b0, 10'h005, 32'h0);
    req_txn(0, 1'b1, 10'h3FF, 32'hA5A5_5A5A);
    req_txn(1, 1'b0, 10'h3FF, 32'h0);

    // p1 holds req across 16 back-to-back writes.
    for (int i = 0; i < 16; i++) begin
      set_req(1, 1'b1, 10'(i), $urandom);
      wait_gnt(1);
      if (i > 0) chk("b2b_spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
      @(posedge clk); #1;
    end
    req[1] = 1'b0;

    do_reset("rst_a");
    fork
      req_txn(0, 1'b0, 10'h001, 32'h0);
      req_txn(1, 1'b0, 10'h002, 32'h0);
    join
    chk("tie1_p1_after_p0", 32'(gc[1] - gc[0]), 32'd3);
    fork
      req_txn(0, 1'b0, 10'h003, 32'h0);
      req_txn(1, 1'b0, 10'h004, 32'h0);
    join
    chk("tie2_p1_after_p0", 32'(gc[1] - gc[0]), 32'd3);

    // p1 pulses only during p0's ACCESS cycle and must be dropped.
    repeat (3) @(posedge clk); #1;
    set_req(0, 1'b1, 10'h010, 32'h1234_5678);
    @(posedge clk); #1;
    set_req(1, 1'b1, 10'h020, 32'hBAD0_BAD0);
    wait_gnt(0);
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (p1_gnt) seen++;
    end
    chk("abort_no_p1_gnt", 32'(seen), 32'd0);

    // Reset lands on the edge that ends a read's ACCESS.
    @(posedge clk); #1;
    set_req(0, 1'b0, 10'h007, 32'h0);
    wait_gnt(0);
    rst_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check_rst_outs("rst_mid_read");
    @(posedge clk); #1;
    rst_n = 1'b1;

    fork
      drive(0, 40);
      drive(1, 40);
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("gnt_q_drained", 32'(egq.size()), 32'd0);
    chk("rvalid_q_drained", 32'(erq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
